controller_reader: RTL and testbench

- Initiator side of the console's gamepad interface: drives latch/clock to two NES-style serial shift-register controllers and captures their 8 button bits.
- Holds stable, atomically updated button snapshots that the 6502 reads through the FPGA data bus whenever the address decoder asserts SELECT_controller.
- Instantiated next to gpu_m inside top_m.
- poll_start is normally tied to the GPU's vblank-start pulse, giving one poll per frame.

---
 rtl/controller_reader_sync2.sv | 22 ++
 rtl/controller_reader.sv | 144 ++++++++++++++
 tb/tb_controller_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_reader_sync2.sv
// rtl/controller_reader_sync2.sv - two-flop synchroniser resetting to the idle line level
module sync2_m (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resolve the asynchronous line into the clock domain; reset to 1 so an idle line reads released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controller_reader.sv
// rtl/controller_reader.sv - NES-style gamepad poller with atomic CPU-readable snapshots
module controller_reader #(
  parameter int HALF_PERIOD  = 76,
  parameter int LATCH_PERIOD = 151
) (
  input  logic       clk_12_5875,
  input  logic       rst_B,
  input  logic       poll_start,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic       ctrl_data0,
  input  logic       ctrl_data1,
  input  logic       cpu_select,
  input  logic       cpu_reg,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       poll_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    LOW   = 2'd2,
    HIGH  = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] LATCH_LAST = 8'(LATCH_PERIOD - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [2:0] bit_idx, bit_next;
  logic       shift_en, capture;
  logic [7:0] sh0, sh1;
  logic [7:0] buttons0, buttons1;
  logic       line0, line1;
  logic       pressed0, pressed1;

  sync2_m u_sync0 (
    .clk   (clk_12_5875),
    .rst_n (rst_B),
    .d     (ctrl_data0),
    .q     (line0)
  );

  sync2_m u_sync1 (
    .clk   (clk_12_5875),
    .rst_n (rst_B),
    .d     (ctrl_data1),
    .q     (line1)
  );

  // Controller lines are active-low; flip so a pressed button is a 1.
  assign pressed0 = ~line0;
  assign pressed1 = ~line1;

  // Sequence latch, then eight low/high clock phases; shift at the end of each low phase.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_en   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // The cycle poll_done is high counts as the tail of the finished poll, so a request there is dropped.
        if (poll_start && !poll_done) begin
          state_next = LATCH;
          cnt_next   = 8'd0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_next = LOW;
          cnt_next   = 8'd0;
          bit_next   = 3'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      LOW: begin
        if (cnt == HALF_LAST) begin
          shift_en   = 1'b1;
          state_next = HIGH;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      HIGH: begin
        if (cnt == HALF_LAST) begin
          cnt_next = 8'd0;
          if (bit_idx == 3'd7) begin
            capture    = 1'b1;
            state_next = IDLE;
          end else begin
            bit_next   = bit_idx + 3'd1;
            state_next = LOW;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shift registers, snapshots and registered pin/status outputs.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_idx    <= 3'd0;
      sh0        <= 8'h00;
      sh1        <= 8'h00;
      buttons0   <= 8'h00;
      buttons1   <= 8'h00;
      poll_done  <= 1'b0;
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      if (shift_en) begin
        sh0 <= {sh0[6:0], pressed0};
        sh1 <= {sh1[6:0], pressed1};
      end
      // Both snapshots change on one edge so the CPU never sees a half-updated pair.
      if (capture) begin
        buttons0 <= sh0;
        buttons1 <= sh1;
      end
      poll_done  <= capture;
      ctrl_latch <= (state_next == LATCH);
      ctrl_clk   <= (state_next == HIGH);
      busy       <= (state_next != IDLE);
    end
  end

  assign data_out = cpu_select ? (cpu_reg ? buttons1 : buttons0) : 8'h00;

endmodule

// File: tb/tb_controller_reader.sv
// tb/tb_controller_reader.sv - randomized self-checking bench for controller_reader
module tb_controller_reader;

  localparam int HP  = 4;
  localparam int LP  = 8;
  localparam int HPD = 76;
  localparam int LPD = 151;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_B = 1'b0;
  logic       poll_start = 1'b0, cpu_select = 1'b0, cpu_reg = 1'b0;
  logic       latch, cclk, busy, poll_done, data0, data1;
  logic [7:0] data_out;

  logic       poll_start_d = 1'b0, cpu_select_d = 1'b0, cpu_reg_d = 1'b0;
  logic       latch_d, cclk_d, busy_d, poll_done_d, data0_d, data1_d;
  logic [7:0] data_out_d;

  controller_reader #(.HALF_PERIOD(HP), .LATCH_PERIOD(LP)) dut (
    .clk_12_5875 (clk),
    .rst_B       (rst_B),
    .poll_start  (poll_start),
    .ctrl_latch  (latch),
    .ctrl_clk    (cclk),
    .ctrl_data0  (data0),
    .ctrl_data1  (data1),
    .cpu_select  (cpu_select),
    .cpu_reg     (cpu_reg),
    .data_out    (data_out),
    .busy        (busy),
    .poll_done   (poll_done)
  );

  controller_reader dut_d (
    .clk_12_5875 (clk),
    .rst_B       (rst_B),
    .poll_start  (poll_start_d),
    .ctrl_latch  (latch_d),
    .ctrl_clk    (cclk_d),
    .ctrl_data0  (data0_d),
    .ctrl_data1  (data1_d),
    .cpu_select  (cpu_select_d),
    .cpu_reg     (cpu_reg_d),
    .data_out    (data_out_d),
    .busy        (busy_d),
    .poll_done   (poll_done_d)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural 4021-style controllers: parallel load while latch is high, shift on clock rise.
  logic [7:0] pressed0 = 8'h00, pressed1 = 8'h00, pressed_d = 8'h00;
  logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF, sr_d = 8'hFF;
  logic       present1 = 1'b0, cclk_q = 1'b0, cclk_dq = 1'b0;

  always @(posedge clk) begin
    if (latch) begin
      sr0 <= ~pressed0;
      sr1 <= ~pressed1;
    end else if (cclk && !cclk_q) begin
      sr0 <= {sr0[6:0], 1'b1};
      sr1 <= {sr1[6:0], 1'b1};
    end
    cclk_q <= cclk;
    if (latch_d) sr_d <= ~pressed_d;
    else if (cclk_d && !cclk_dq) sr_d <= {sr_d[6:0], 1'b1};
    cclk_dq <= cclk_d;
  end

  assign data0   = sr0[7];
  assign data1   = present1 ? sr1[7] : 1'b1;
  assign data0_d = sr_d[7];
  assign data1_d = 1'b1;

  // Reference snapshots: what the CPU should read, updated only when a poll completes.
  logic [7:0] snap0 = 8'h00, snap1 = 8'h00;

  function automatic logic [7:0] exp_read(input logic sel, input logic r);
    return sel ? (r ? snap1 : snap0) : 8'h00;
  endfunction

  task automatic read_checks(input string tag);
    for (int i = 0; i < 4; i++) begin
      cpu_select = (i != 3);
      cpu_reg    = 1'(i & 1);
      #1;
      check({tag, "_read"}, data_out, exp_read(cpu_select, cpu_reg));
    end
  endtask

  task automatic run_poll(input string tag, input int busy_start_at, input bit repulse_at_done);
    int lat = -1;
    int latch_rises = 0;
    int clk_rises = 0;
    logic lprev, cprev;
    bit done = 0;
    @(negedge clk);
    lprev = latch;
    cprev = cclk;
    poll_start = 1'b1;
    @(posedge clk);
    #1 poll_start = 1'b0;
    for (int n = 1; n <= 400 && !done; n++) begin
      @(posedge clk);
      #1;
      if (latch && !lprev) latch_rises++;
      if (cclk && !cprev) clk_rises++;
      lprev = latch;
      cprev = cclk;
      if (poll_done) begin
        lat  = n + 1;
        done = 1;
      end
      poll_start = (n == busy_start_at) || (done && repulse_at_done);
      if (!done && (n % 8 == 0)) begin
        cpu_select = 1'b1;
        cpu_reg    = 1'($urandom_range(0, 1));
        #1;
        check({tag, "_hold"}, data_out, exp_read(1'b1, cpu_reg));
      end
    end
    check({tag, "_latency"}, lat, 1 + LP + 16 * HP);
    check({tag, "_latch_pulses"}, latch_rises, 1);
    check({tag, "_clk_pulses"}, clk_rises, 8);
    snap0 = pressed0;
    snap1 = present1 ? pressed1 : 8'h00;
    read_checks(tag);
    @(posedge clk);
    #1 poll_start = 1'b0;
    check({tag, "_done_pulse"}, poll_done, 1'b0);
    check({tag, "_idle_after"}, {busy, latch}, 2'b00);
  endtask

  initial begin
    int rises;
    int lat_d, hi_len, hi_min, hi_max, rises_d;
    bit seen;

    // Reset state
    cpu_select = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {latch, cclk, busy, poll_done}, 4'b0000);
    cpu_reg = 1'b0;
    #1 check("rst_read0", data_out, 8'h00);
    cpu_reg = 1'b1;
    #1 check("rst_read1", data_out, 8'h00);
    @(negedge clk) rst_B = 1'b1;
    rises = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 if (cclk || latch || busy) rises++;
    end
    check("post_rst_quiet", rises, 0);

    // Single poll, absent controller 1
    pressed0 = 8'hA5;
    present1 = 1'b0;
    run_poll("single", -1, 0);

    // Atomic snapshot: every button pressed
    pressed0 = 8'hFF;
    run_poll("atomic", -1, 0);

    // Ignored starts while busy and in the poll_done cycle
    pressed0 = 8'($urandom);
    pressed1 = 8'($urandom);
    present1 = 1'b1;
    run_poll("busy", 20, 1);

    // Random polls
    for (int k = 0; k < 4; k++) begin
      pressed0 = 8'($urandom);
      pressed1 = 8'($urandom);
      present1 = 1'($urandom_range(0, 1));
      run_poll("rand", (k == 2) ? int'($urandom_range(2, 60)) : -1, 1'(k & 1));
    end

    // Reset during the fourth HIGH phase
    pressed0 = 8'($urandom);
    pressed1 = 8'($urandom);
    @(negedge clk) poll_start = 1'b1;
    @(posedge clk);
    #1 poll_start = 1'b0;
    rises = 0;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk);
      #1 if (cclk && !cclk_q) rises++;
      if (rises == 4) seen = 1;
    end
    check("midrst_reach_high4", seen, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_B = 1'b0;
    #1;
    check("midrst_outputs", {latch, cclk, busy, poll_done}, 4'b0000);
    snap0 = 8'h00;
    snap1 = 8'h00;
    read_checks("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_B = 1'b1;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1 if (poll_done) seen = 1;
    end
    check("midrst_no_done", seen, 1'b0);
    pressed0 = 8'($urandom);
    pressed1 = 8'($urandom);
    present1 = 1'b1;
    run_poll("after_rst", -1, 0);

    // Default timing instance
    pressed_d = 8'($urandom);
    cpu_select_d = 1'b1;
    @(negedge clk) poll_start_d = 1'b1;
    @(posedge clk);
    #1 poll_start_d = 1'b0;
    lat_d = -1;
    hi_len = 0;
    hi_min = 9999;
    hi_max = 0;
    rises_d = 0;
    for (int n = 1; n <= 3000 && lat_d < 0; n++) begin
      @(posedge clk);
      #1;
      if (cclk_d) begin
        if (hi_len == 0) rises_d++;
        hi_len++;
      end else if (hi_len != 0) begin
        if (hi_len < hi_min) hi_min = hi_len;
        if (hi_len > hi_max) hi_max = hi_len;
        hi_len = 0;
      end
      if (poll_done_d) lat_d = n + 1;
    end
    check("dflt_latency", lat_d, 1 + LPD + 16 * HPD);
    check("dflt_high_min", hi_min, HPD);
    check("dflt_high_max", hi_max, HPD);
    check("dflt_clk_pulses", rises_d, 8);
    cpu_reg_d = 1'b0;
    #1 check("dflt_read0", data_out_d, pressed_d);
    cpu_reg_d = 1'b1;
    #1 check("dflt_read1", data_out_d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
